lipsi_ctrl: RTL and testbench

- Multi-cycle sequencer for the Lipsi accumulator datapath.
- Fetches instruction bytes from program memory and decodes them.
- Drives the ALU control code, accumulator write-enable, operand select and data-memory access.
- Sits between program memory, data memory, the ALU and the accumulator register; owns the PC.

---
 rtl/lipsi_pkg.sv | 68 ++++++
 rtl/lipsi_ctrl_if.sv | 23 ++
 rtl/lipsi_decode.sv | 34 +++
 rtl/lipsi_ctrl.sv | 138 +++++++++++++
 tb/tb_lipsi_ctrl.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/lipsi_pkg.sv
// Shared types and encodings for the Lipsi controller: state codes, opcode
// prefixes, ALU operation codes and branch conditions.
package lipsi_pkg;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2,
    HALT   = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    CL_NOP,
    CL_ALU_REG,
    CL_ST,
    CL_ALU_IMM,
    CL_BR,
    CL_SHIFT,
    CL_EXIT
  } iclass_e;

  // Opcode prefixes, each matched against the top bits of the instruction byte
  localparam logic       OP_ALU_REG = 1'b0;
  localparam logic [3:0] OP_ST      = 4'b1000;
  localparam logic [4:0] OP_ALU_IMM = 5'b11000;
  localparam logic [5:0] OP_BR      = 6'b110100;
  localparam logic [5:0] OP_SHIFT   = 6'b111000;
  localparam logic [7:0] OP_EXIT    = 8'hFF;

  localparam logic [3:0] ALU_PASS = 4'b0000;
  localparam logic [3:0] ALU_SHL  = 4'b0100;
  localparam logic [3:0] ALU_SHR  = 4'b0101;
  localparam logic [3:0] ALU_ASL  = 4'b0110;
  localparam logic [3:0] ALU_ASR  = 4'b0111;
  localparam logic [3:0] ALU_ADD  = 4'b1000;
  localparam logic [3:0] ALU_SUB  = 4'b1001;
  localparam logic [3:0] ALU_ADC  = 4'b1010;
  localparam logic [3:0] ALU_SBB  = 4'b1011;
  localparam logic [3:0] ALU_AND  = 4'b1100;
  localparam logic [3:0] ALU_OR   = 4'b1101;
  localparam logic [3:0] ALU_XOR  = 4'b1110;
  localparam logic [3:0] ALU_LD   = 4'b1111;

  localparam logic [1:0] BR_ALWAYS = 2'b00;
  localparam logic [1:0] BR_ZERO   = 2'b01;
  localparam logic [1:0] BR_NZERO  = 2'b10;
  localparam logic [1:0] BR_NEVER  = 2'b11;

  typedef struct packed {
    iclass_e    cls;
    logic [2:0] fff;
    logic [3:0] rrrr;
    logic [1:0] ss;
    logic [1:0] bb;
  } dec_t;

  function automatic logic br_taken(input logic [1:0] bb, input logic acc_zero);
    logic taken;
    case (bb)
      BR_ALWAYS: taken = 1'b1;
      BR_ZERO:   taken = acc_zero;
      BR_NZERO:  taken = !acc_zero;
      default:   taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/lipsi_ctrl_if.sv
// Bus bundle between the Lipsi controller and its program memory, data memory,
// ALU and accumulator. master = controller side, slave = datapath/memory side.
interface lipsi_ctrl_if #(parameter int PC_W = 8);
  logic [PC_W-1:0] pmem_addr;
  logic [7:0]      pmem_rdata;
  logic [7:0]      dmem_addr;
  logic            dmem_re;
  logic            dmem_we;
  logic [3:0]      alu_ctrl;
  logic            operand_sel;
  logic            acc_we;
  logic            acc_zero;

  modport master (
    output pmem_addr, dmem_addr, dmem_re, dmem_we, alu_ctrl, operand_sel, acc_we,
    input  pmem_rdata, acc_zero
  );

  modport slave (
    input  pmem_addr, dmem_addr, dmem_re, dmem_we, alu_ctrl, operand_sel, acc_we,
    output pmem_rdata, acc_zero
  );
endinterface

// File: rtl/lipsi_decode.sv
// Combinational instruction decoder: splits one instruction byte into its
// class and operand fields.
module lipsi_decode
  import lipsi_pkg::*;
(
  input  logic [7:0] i_instr,
  output dec_t       o_dec
);

  // NOTE: every field gets a default before the priority chain so no path
  // leaves a field unassigned and no latch is inferred.
  always_comb begin
    o_dec.cls  = CL_NOP;
    o_dec.fff  = i_instr[6:4];
    o_dec.rrrr = i_instr[3:0];
    o_dec.ss   = i_instr[1:0];
    o_dec.bb   = i_instr[1:0];
    if (i_instr[7] == OP_ALU_REG) begin
      o_dec.cls = CL_ALU_REG;
    end else if (i_instr[7:4] == OP_ST) begin
      o_dec.cls = CL_ST;
    end else if (i_instr[7:3] == OP_ALU_IMM) begin
      o_dec.cls = CL_ALU_IMM;
      o_dec.fff = i_instr[2:0];
    end else if (i_instr[7:2] == OP_BR) begin
      o_dec.cls = CL_BR;
    end else if (i_instr[7:2] == OP_SHIFT) begin
      o_dec.cls = CL_SHIFT;
    end else if (i_instr == OP_EXIT) begin
      o_dec.cls = CL_EXIT;
    end
  end

endmodule

// File: rtl/lipsi_ctrl.sv
// Lipsi multi-cycle sequencer: owns the PC, fetches/decodes instruction bytes and
// drives ALU, accumulator and data-memory controls. LIPSI_HALT_EN enables 8'hFF = halt.
module lipsi_ctrl
  import lipsi_pkg::*;
#(
  parameter int         PC_W     = 8,
  parameter logic [7:0] REG_BASE = 8'h00
) (
  input  logic            clk,
  input  logic            rst_n,
  lipsi_ctrl_if.master    bus,
  output logic [PC_W-1:0] pc,
  output logic            halted
);

  localparam logic [1:0] S_FETCH  = FETCH;
  localparam logic [1:0] S_DECODE = DECODE;
  localparam logic [1:0] S_EXEC   = EXEC;
`ifdef LIPSI_HALT_EN
  localparam logic [1:0] S_HALT   = HALT;
`endif

  logic [1:0]      r_state;
  logic [PC_W-1:0] r_pc;
  logic [7:0]      r_ir;

  logic [7:0]      w_instr;
  dec_t            w_dec;
  logic [PC_W-1:0] w_pc_inc;
  logic            w_halt_op;

  // DECODE looks at the byte arriving from memory; EXEC at the latched copy
  assign w_instr  = (r_state == S_DECODE) ? bus.pmem_rdata : r_ir;
  assign w_pc_inc = r_pc + PC_W'(1);

  lipsi_decode u_decode (
    .i_instr (w_instr),
    .o_dec   (w_dec)
  );

`ifdef LIPSI_HALT_EN
  assign w_halt_op = (w_dec.cls == CL_EXIT);
`else
  assign w_halt_op = 1'b0;
`endif

  // NOTE: state uses non-blocking assignments so every register samples the
  // values from before this edge; reset is synchronous, checked on the clock edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
      r_pc    <= '0;
      r_ir    <= '0;
    end else begin
      case (r_state)
        S_FETCH: begin
          r_pc    <= w_pc_inc;
          r_state <= S_DECODE;
        end
        S_DECODE: begin
          r_ir <= bus.pmem_rdata;
          case (w_dec.cls)
            CL_ALU_REG: r_state <= S_EXEC;
            CL_ALU_IMM, CL_BR: begin
              r_pc    <= w_pc_inc;
              r_state <= S_EXEC;
            end
            default: begin
`ifdef LIPSI_HALT_EN
              r_state <= w_halt_op ? S_HALT : S_FETCH;
`else
              r_state <= S_FETCH;
`endif
            end
          endcase
        end
        S_EXEC: begin
          // The second byte is on pmem_rdata now; pc already points past it
          if (w_dec.cls == CL_BR && br_taken(w_dec.bb, bus.acc_zero))
            r_pc <= PC_W'(bus.pmem_rdata);
          r_state <= S_FETCH;
        end
`ifdef LIPSI_HALT_EN
        S_HALT: r_state <= S_HALT;
`endif
        default: r_state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    bus.dmem_addr   = '0;
    bus.dmem_re     = 1'b0;
    bus.dmem_we     = 1'b0;
    bus.alu_ctrl    = ALU_PASS;
    bus.operand_sel = 1'b0;
    bus.acc_we      = 1'b0;
    if (rst_n) begin
      case (r_state)
        S_DECODE: begin
          case (w_dec.cls)
            CL_ALU_REG: begin
              bus.dmem_addr = REG_BASE + {4'h0, w_dec.rrrr};
              bus.dmem_re   = 1'b1;
            end
            CL_ST: begin
              bus.dmem_addr = REG_BASE + {4'h0, w_dec.rrrr};
              bus.dmem_we   = 1'b1;
            end
            CL_SHIFT: begin
              bus.alu_ctrl = {2'b01, w_dec.ss};
              bus.acc_we   = 1'b1;
            end
            default: ;
          endcase
        end
        S_EXEC: begin
          if (w_dec.cls == CL_ALU_REG || w_dec.cls == CL_ALU_IMM) begin
            bus.alu_ctrl    = {1'b1, w_dec.fff};
            bus.operand_sel = (w_dec.cls == CL_ALU_IMM);
            bus.acc_we      = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.pmem_addr = r_pc;
  assign pc            = r_pc;

`ifdef LIPSI_HALT_EN
  assign halted = rst_n && (r_state == S_HALT);
`else
  assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_lipsi_ctrl.sv
// Scoreboard bench for lipsi_ctrl: per-cycle expectations are queued with the
// stimulus, then popped and compared mid-cycle against the DUT outputs.
module tb_lipsi_ctrl;

  logic       clk;
  logic       rst_n;
  logic [7:0] pc;
  logic       halted;
  logic [7:0] pmem [256];

  int n_cmp = 0;
  int n_err = 0;

  lipsi_ctrl_if #(.PC_W(8)) bus ();

  lipsi_ctrl #(.PC_W(8), .REG_BASE(8'h00)) u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus),
    .pc     (pc),
    .halted (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read program memory
  always @(posedge clk) bus.pmem_rdata <= pmem[bus.pmem_addr];

  typedef struct {
    string      tag;
    bit         rst;
    bit         az;
    bit         chk_pc;
    logic [7:0] pc;
    bit         re;
    bit         we;
    logic [7:0] daddr;
    logic [3:0] alu;
    bit         osel;
    bit         accwe;
    bit         hlt;
  } vec_t;

  vec_t sb[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input string tag, input bit rst, input bit az, input bit chk_pc,
                      input logic [7:0] epc, input bit re, input bit we,
                      input logic [7:0] daddr, input logic [3:0] alu,
                      input bit osel, input bit accwe, input bit hlt);
    vec_t v;
    v.tag = tag; v.rst = rst; v.az = az; v.chk_pc = chk_pc; v.pc = epc;
    v.re = re; v.we = we; v.daddr = daddr; v.alu = alu;
    v.osel = osel; v.accwe = accwe; v.hlt = hlt;
    sb.push_back(v);
  endtask

  task automatic push_idle(input string tag, input bit az, input logic [7:0] epc);
    push(tag, 1'b1, az, 1'b1, epc, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic push_reset(input string tag);
    push(tag, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0);
    push(tag, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic clear_pmem();
    for (int i = 0; i < 256; i++) pmem[i] = 8'hF0;
  endtask

  task automatic run_sb();
    vec_t v;
    while (sb.size() > 0) begin
      @(negedge clk);
      v            = sb.pop_front();
      rst_n        = v.rst;
      bus.acc_zero = v.az;
      #1;
      if (v.chk_pc) begin
        check({v.tag, ".pc"}, 32'(pc), 32'(v.pc));
        check({v.tag, ".pmem_addr"}, 32'(bus.pmem_addr), 32'(v.pc));
      end
      check({v.tag, ".dmem_re"}, 32'(bus.dmem_re), 32'(v.re));
      check({v.tag, ".dmem_we"}, 32'(bus.dmem_we), 32'(v.we));
      if (v.re || v.we) check({v.tag, ".dmem_addr"}, 32'(bus.dmem_addr), 32'(v.daddr));
      check({v.tag, ".alu_ctrl"}, 32'(bus.alu_ctrl), 32'(v.alu));
      check({v.tag, ".operand_sel"}, 32'(bus.operand_sel), 32'(v.osel));
      check({v.tag, ".acc_we"}, 32'(bus.acc_we), 32'(v.accwe));
      check({v.tag, ".halted"}, 32'(halted), 32'(v.hlt));
    end
  endtask

  logic [7:0] alu_ops [3];
  logic [7:0] br_op   [7];
  bit         br_az   [7];
  logic [7:0] br_pc   [7];

  initial begin
    rst_n        = 1'b0;
    bus.acc_zero = 1'b0;

    // ALU register instructions: ADD r3, LD r10, AND r5
    alu_ops = '{8'h03, 8'h7A, 8'h45};
    for (int i = 0; i < 3; i++) begin
      clear_pmem();
      pmem[0] = alu_ops[i];
      push_reset("alur.rst");
      push_idle("alur.fetch", 1'b0, 8'h00);
      push("alur.dec", 1'b1, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0, {4'h0, alu_ops[i][3:0]},
           4'h0, 1'b0, 1'b0, 1'b0);
      push("alur.exec", 1'b1, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0, 8'h00,
           {1'b1, alu_ops[i][6:4]}, 1'b0, 1'b1, 1'b0);
      push_idle("alur.fetch2", 1'b0, 8'h01);
      push_idle("alur.nop", 1'b0, 8'h02);
      run_sb();
    end

    // Reset held for 3 cycles starting in EXEC of ADD r3
    clear_pmem();
    pmem[0] = 8'h03;
    push_reset("rmid.rst");
    push_idle("rmid.fetch", 1'b0, 8'h00);
    push("rmid.dec", 1'b1, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0, 8'h03, 4'h0, 1'b0, 1'b0, 1'b0);
    push("rmid.hold0", 1'b0, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0);
    push("rmid.hold1", 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0);
    push("rmid.hold2", 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0);
    push_idle("rmid.fetch2", 1'b0, 8'h00);
    push("rmid.dec2", 1'b1, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0, 8'h03, 4'h0, 1'b0, 1'b0, 1'b0);
    run_sb();

    // ALU immediate: SUB #10
    clear_pmem();
    pmem[0] = 8'hC1;
    pmem[1] = 8'h0A;
    push_reset("alui.rst");
    push_idle("alui.fetch", 1'b0, 8'h00);
    push_idle("alui.dec", 1'b0, 8'h01);
    push("alui.exec", 1'b1, 1'b0, 1'b1, 8'h02, 1'b0, 1'b0, 8'h00, 4'b1001, 1'b1, 1'b1, 1'b0);
    push_idle("alui.fetch2", 1'b0, 8'h02);
    run_sb();

    // Branches to 8'h40: opcode, acc_zero, resulting pc
    br_op = '{8'hD1, 8'hD1, 8'hD3, 8'hD3, 8'hD0, 8'hD2, 8'hD2};
    br_az = '{1'b1,  1'b0,  1'b1,  1'b0,  1'b0,  1'b0,  1'b1};
    br_pc = '{8'h40, 8'h02, 8'h02, 8'h02, 8'h40, 8'h40, 8'h02};
    for (int i = 0; i < 7; i++) begin
      clear_pmem();
      pmem[0] = br_op[i];
      pmem[1] = 8'h40;
      push_reset("br.rst");
      push_idle("br.fetch", br_az[i], 8'h00);
      push_idle("br.dec", br_az[i], 8'h01);
      push_idle("br.exec", br_az[i], 8'h02);
      push_idle($sformatf("br%0d.target", i), br_az[i], br_pc[i]);
      run_sb();
    end

    // Store r5
    clear_pmem();
    pmem[0] = 8'h85;
    push_reset("st.rst");
    push_idle("st.fetch", 1'b0, 8'h00);
    push("st.dec", 1'b1, 1'b0, 1'b1, 8'h01, 1'b0, 1'b1, 8'h05, 4'h0, 1'b0, 1'b0, 1'b0);
    push_idle("st.fetch2", 1'b0, 8'h01);
    push_idle("st.nop", 1'b0, 8'h02);
    run_sb();

    // Shifts, all four variants
    for (int s = 0; s < 4; s++) begin
      clear_pmem();
      pmem[0] = 8'hE0 | 8'(s);
      push_reset("sh.rst");
      push_idle("sh.fetch", 1'b0, 8'h00);
      push($sformatf("sh%0d.dec", s), 1'b1, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0, 8'h00,
           4'b0100 | 4'(s), 1'b0, 1'b1, 1'b0);
      push_idle("sh.fetch2", 1'b0, 8'h01);
      run_sb();
    end

    // 8'hFF at address 7: halt when enabled, NOP otherwise
    clear_pmem();
    pmem[7] = 8'hFF;
    push_reset("hlt.rst");
    for (int k = 0; k < 7; k++) begin
      push_idle("hlt.fetch", 1'b0, 8'(k));
      push_idle("hlt.nop", 1'b0, 8'(k + 1));
    end
    push_idle("hlt.fetch7", 1'b0, 8'h07);
    push_idle("hlt.decff", 1'b0, 8'h08);
`ifdef LIPSI_HALT_EN
    for (int k = 0; k < 4; k++)
      push("hlt.held", 1'b1, 1'b0, 1'b1, 8'h08, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0, 1'b0, 1'b1);
`else
    push_idle("hlt.fetch8", 1'b0, 8'h08);
    push_idle("hlt.dec8", 1'b0, 8'h09);
    push_idle("hlt.fetch9", 1'b0, 8'h09);
    push_idle("hlt.dec9", 1'b0, 8'h0A);
`endif
    run_sb();

    // Two-byte branch at FF: second byte comes from address 00
    for (int i = 0; i < 2; i++) begin
      clear_pmem();
      pmem[0]    = 8'hD0;
      pmem[1]    = 8'hFE;
      pmem[8'hFF] = (i == 0) ? 8'hD0 : 8'hD3;
      push_reset("wrap.rst");
      push_idle("wrap.fetch", 1'b0, 8'h00);
      push_idle("wrap.dec", 1'b0, 8'h01);
      push_idle("wrap.exec", 1'b0, 8'h02);
      push_idle("wrap.fetchfe", 1'b0, 8'hFE);
      push_idle("wrap.nopfe", 1'b0, 8'hFF);
      push_idle("wrap.fetchff", 1'b0, 8'hFF);
      push_idle("wrap.decff", 1'b0, 8'h00);
      push_idle("wrap.execff", 1'b0, 8'h01);
      push_idle($sformatf("wrap%0d.target", i), 1'b0, (i == 0) ? 8'hD0 : 8'h01);
      run_sb();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
